// File: rtl/uart_pkg.sv
// Shared types and constants for the debug/programming UART.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam int unsigned UART_CLK_DIV_115200 = 868;

endpackage

// File: rtl/word_fifo.sv
// Circular word FIFO with registered full/empty flags and a synchronous active-low reset.
module word_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flags are registered from the next count so they always agree with count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/uart_word_tx.sv
// UART word transmitter: buffers 32-bit words and sends each as four 8N1 frames, LSB byte first.
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = UART_CLK_DIV_115200,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        Rst,
    input  logic [31:0]                 word_in,
    input  logic                        word_valid,
    output logic                        word_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned BAUD_W = $clog2(CLK_DIV);

    tx_state_t                    state_q;
    logic [BAUD_W-1:0]            baud_q;
    logic [2:0]                   bit_idx_q;
    logic [1:0]                   byte_idx_q;
    logic [31:0]                  shifter_q;
    logic                         tx_q;
    logic                         busy_q;
    logic                         run_q;

    logic                         push;
    logic                         pop;
    logic [31:0]                  pop_data;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]  count_next;
    logic                         baud_done;
    logic                         idle_next;
    logic                         line_bit;

    assign word_ready = run_q && !fifo_full;
    assign push       = word_valid && word_ready;
    assign pop        = (state_q == LOAD);
    assign baud_done  = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign tx         = tx_q;
    assign busy       = busy_q;

    word_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (Rst),
        .push       (push),
        .push_data  (word_in),
        .pop        (pop),
        .pop_data   (pop_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .count_next (count_next)
    );

    always_comb begin
        idle_next = ((state_q == IDLE) && fifo_empty) ||
                    ((state_q == STOP) && baud_done && (byte_idx_q == 2'd3) && fifo_empty);
    end

    always_comb begin
        line_bit = 1'b1;
        case (state_q)
            START:   line_bit = 1'b0;
            DATA:    line_bit = shifter_q[bit_idx_q];
            default: line_bit = 1'b1;
        endcase
    end

    // tx is registered from the current state, so the line trails the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            shifter_q  <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            tx_q   <= line_bit;
            busy_q <= !idle_next || (count_next != '0);
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (!fifo_empty) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shifter_q  <= pop_data;
                    byte_idx_q <= '0;
                    baud_q     <= '0;
                    state_q    <= START;
                end
                START: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (byte_idx_q != 2'd3) begin
                            byte_idx_q <= byte_idx_q + 1'b1;
                            shifter_q  <= {8'h00, shifter_q[31:8]};
                            state_q    <= START;
                        end else if (!fifo_empty) begin
                            state_q <= LOAD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: waveform model, UART decoder scoreboard, reset checks.
module tb_uart_word_tx;

    localparam int unsigned D1 = 4;
    localparam int unsigned D2 = 2;

    logic        clk = 1'b0;
    logic        Rst = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_ready;
    logic        tx;
    logic        busy;
    logic [2:0]  fifo_count;
    logic [31:0] word_in2 = '0;
    logic        word_valid2 = 1'b0;
    logic        word_ready2;
    logic        tx2;
    logic        busy2;
    logic [2:0]  fifo_count2;

    int          n_vec = 0;
    int          n_err = 0;
    int          k_now = 0;
    logic [31:0] exp_words[$];
    logic [7:0]  exp_bytes[$];
    bit          mon_on = 1'b0;
    bit          mon_act = 1'b0;
    int          mon_cnt = 0;
    int          rx_n = 0;
    logic [7:0]  mon_sh = '0;

    always #5 clk = ~clk;

    uart_word_tx #(.CLK_DIV(D1), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .Rst        (Rst),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_word_tx #(.CLK_DIV(D2), .FIFO_DEPTH(4)) dut2 (
        .clk        (clk),
        .Rst        (Rst),
        .word_in    (word_in2),
        .word_valid (word_valid2),
        .word_ready (word_ready2),
        .tx         (tx2),
        .busy       (busy2),
        .fifo_count (fifo_count2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected line level k cycles after the first push into an idle block,
    // with every word of exp_words already queued before the first finishes.
    function automatic logic exp_line(input int k, input int d);
        int p, wlen, j, r, f, b;
        logic [31:0] w;
        logic [7:0] by;
        if (k < 3) return 1'b1;
        p = k - 3;
        wlen = 40 * d + 1;
        j = p / wlen;
        r = p % wlen;
        if (j >= exp_words.size() || r >= 40 * d) return 1'b1;
        w = exp_words[j];
        f = r / (10 * d);
        b = (r % (10 * d)) / d;
        by = w[8*f +: 8];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return by[b-1];
    endfunction

    task automatic wave_to(input int sel, input int d, input int kend);
        while (k_now < kend) begin
            @(posedge clk); #1;
            k_now++;
            if (sel == 0) check("tx_wave", tx, exp_line(k_now, d));
            else          check("tx2_wave", tx2, exp_line(k_now, d));
        end
    endtask

    // Pushes exp_words[0..n-1] on consecutive edges; pops begin two edges after the first push.
    task automatic push_burst(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel == 0) begin word_valid = 1'b1; word_in = exp_words[i]; end
            else begin word_valid2 = 1'b1; word_in2 = exp_words[i]; end
            @(posedge clk); #1;
            if (sel == 0) check("fifo_count_burst", fifo_count, (i + 1) - ((i >= 2) ? 1 : 0));
            else          check("fifo_count2_burst", fifo_count2, (i + 1) - ((i >= 2) ? 1 : 0));
        end
        word_valid = 1'b0;
        word_valid2 = 1'b0;
        k_now = n - 1;
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        word_valid = 1'b0;
        word_valid2 = 1'b0;
        Rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", word_ready, 0);
        check("rst_count", fifo_count, 0);
        Rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", word_ready, 1);
    endtask

    // UART decoder: samples mid-bit after a falling edge on an idle line.
    always @(posedge clk) begin
        #1;
        if (!mon_on || !Rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % D1 == D1 / 2) begin
                if (mon_cnt / D1 == 0) begin
                    check("rx_start", tx, 0);
                end else if (mon_cnt / D1 <= 8) begin
                    mon_sh[mon_cnt/D1-1] = tx;
                end else begin
                    check("rx_stop", tx, 1);
                    check("rx_expected_pending", exp_bytes.size() != 0, 1);
                    if (exp_bytes.size() != 0) check("rx_byte", mon_sh, exp_bytes.pop_front());
                    rx_n++;
                    mon_act = 1'b0;
                end
            end
        end
    end

    initial begin
        int acc, k, pushed;
        logic rdy;

        // 1: single word, exact waveform, latency and busy window
        do_reset();
        exp_words = {32'h44332211};
        push_burst(0, 1);
        check("busy_on_push", busy, 1);
        wave_to(0, D1, 161);
        check("busy_late", busy, 1);
        wave_to(0, D1, 163);
        check("busy_done", busy, 0);
        wave_to(0, D1, 170);

        // 2: three words back to back
        do_reset();
        exp_words = {};
        repeat (3) exp_words.push_back($urandom);
        push_burst(0, 3);
        wave_to(0, D1, 3 + 3 * 161 + 5);
        check("b2b_count_drained", fifo_count, 0);
        check("b2b_busy_drained", busy, 0);

        // 3: hold valid until full, then watch ready return
        do_reset();
        word_valid = 1'b1;
        word_in = $urandom;
        acc = 0;
        k = -1;
        while (k < 10) begin
            rdy = word_ready;
            @(posedge clk); #1;
            k++;
            if (rdy) begin
                acc++;
                word_in = $urandom;
            end
        end
        word_valid = 1'b0;
        check("accepted_when_full", acc, 5);
        check("ready_when_full", word_ready, 0);
        check("count_when_full", fifo_count, 4);
        while (k < 162) begin @(posedge clk); #1; k++; end
        check("ready_during_load2", word_ready, 0);
        @(posedge clk); #1;
        check("ready_after_load2", word_ready, 1);
        check("count_after_load2", fifo_count, 3);

        // 4: reset during bit 3 of byte 2, then a clean word
        do_reset();
        exp_words = {};
        repeat (2) exp_words.push_back($urandom);
        push_burst(0, 2);
        wave_to(0, D1, 100);
        Rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_ready", word_ready, 0);
        Rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_release_ready", word_ready, 1);
        check("midrst_release_tx", tx, 1);
        exp_words = {32'hA5A5A5A5};
        push_burst(0, 1);
        wave_to(0, D1, 170);
        check("a5_busy_done", busy, 0);

        // 5: CLK_DIV=2 with all-zero and all-one words
        do_reset();
        exp_words = {32'h00000000, 32'hFFFFFFFF};
        push_burst(1, 2);
        wave_to(1, D2, 3 + 2 * 81 + 4);
        check("div2_busy_done", busy2, 0);

        // 6: random valid over 200 words against the decoder
        do_reset();
        mon_on = 1'b1;
        rx_n = 0;
        exp_bytes = {};
        pushed = 0;
        for (int c = 0; c < 60000 && pushed < 200; c++) begin
            word_valid = 1'($urandom_range(0, 1));
            word_in = $urandom;
            rdy = word_ready;
            @(posedge clk); #1;
            if (word_valid && rdy) begin
                for (int b = 0; b < 4; b++) exp_bytes.push_back(word_in[8*b +: 8]);
                pushed++;
            end
        end
        word_valid = 1'b0;
        check("rand_pushed", pushed, 200);
        for (int c = 0; c < 3000 && busy; c++) begin @(posedge clk); #1; end
        check("rand_drain_busy", busy, 0);
        repeat (50) @(posedge clk);
        #1;
        check("rand_rx_bytes", rx_n, 800);
        check("rand_leftover", exp_bytes.size(), 0);
        mon_on = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
